// File: rtl/sc_nn_decoder.sv
// -----------------------------------------------------------------------------
// sc_nn_decoder
//   Stochastic-computing output decoder. Each of N2 class streams delivers one
//   stochastic bit per accepted sample. Over a window of 2^L accepted samples
//   the block counts ones per class, then scans the counters one class per
//   cycle to find the argmax (ties go to the lowest index), and presents the
//   winner with a valid/ready handshake.
//
//   Configuration macro: SC_DEC_BIPOLAR_EN
//     undefined : class_val = winning count, zero-extended to CW+1 bits
//     defined   : class_val = 2*count - 2^L, two's complement (bipolar code)
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high reset
//   start      in   1      open a new window (honoured only in IDLE)
//   din        in   N2     one stochastic bit per class
//   din_valid  in   1      din carries a valid sample this cycle
//   busy       out  1      high while accumulating or scanning
//   out_valid  out  1      result available
//   out_ready  in   1      consumer accepts result
//   class_idx  out  IW     winning class index
//   class_val  out  CW+1   winning class value (format set by macro above)
// -----------------------------------------------------------------------------
module sc_nn_decoder #(
    parameter int  N2 = 10,
    parameter int  L  = 8,
    localparam int CW = L + 1,
    localparam int IW = $clog2(N2)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [N2-1:0] din,
    input  logic          din_valid,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] class_idx,
    output logic [CW:0]   class_val
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_ARGMAX = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    localparam logic [L-1:0]  SAMP_LAST = {L{1'b1}};
    localparam logic [L-1:0]  SAMP_ONE  = {{(L-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0] K_LAST    = IW'(N2 - 1);
    localparam logic [IW-1:0] K_ONE     = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0] K_ZERO    = {IW{1'b0}};

    state_t        state_q;
    logic [CW-1:0] cnt_q [N2];
    logic [L-1:0]  samp_q;
    logic [IW-1:0] k_q;
    logic [CW-1:0] best_q;
    logic [IW-1:0] best_idx_q;
    logic [CW-1:0] best_d;
    logic [IW-1:0] best_idx_d;
    logic          busy_q;
    logic          out_valid_q;
    logic [IW-1:0] class_idx_q;
    logic [CW:0]   class_val_q;

    // Map a raw count onto the output value encoding.
    function automatic logic [CW:0] fmt_val(input logic [CW-1:0] b);
`ifdef SC_DEC_BIPOLAR_EN
        // 2*b - 2^L; wraps naturally into two's complement at CW+1 bits.
        fmt_val = {b, 1'b0} - {2'b01, {L{1'b0}}};
`else
        fmt_val = {1'b0, b};
`endif
    endfunction

    // Argmax step: class k=0 seeds the running best; later classes replace it
    // only when strictly larger, so ties keep the lower index.
    always_comb begin
        best_d     = best_q;
        best_idx_d = best_idx_q;
        if ((k_q == K_ZERO) || (cnt_q[k_q] > best_q)) begin
            best_d     = cnt_q[k_q];
            best_idx_d = k_q;
        end else begin
            best_d     = best_q;
            best_idx_d = best_idx_q;
        end
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            samp_q      <= {L{1'b0}};
            k_q         <= K_ZERO;
            best_q      <= {CW{1'b0}};
            best_idx_q  <= K_ZERO;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            class_idx_q <= K_ZERO;
            class_val_q <= {(CW+1){1'b0}};
            for (int i = 0; i < N2; i++) begin
                cnt_q[i] <= {CW{1'b0}};
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < N2; i++) begin
                            cnt_q[i] <= {CW{1'b0}};
                        end
                        samp_q  <= {L{1'b0}};
                        busy_q  <= 1'b1;
                        state_q <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (din_valid) begin
                        for (int i = 0; i < N2; i++) begin
                            cnt_q[i] <= cnt_q[i] + {{(CW-1){1'b0}}, din[i]};
                        end
                        samp_q <= samp_q + SAMP_ONE;
                        // The last sample is still counted above; scan starts next cycle.
                        if (samp_q == SAMP_LAST) begin
                            k_q     <= K_ZERO;
                            state_q <= S_ARGMAX;
                        end
                    end
                end
                S_ARGMAX: begin
                    best_q     <= best_d;
                    best_idx_q <= best_idx_d;
                    if (k_q == K_LAST) begin
                        // Outputs take the final comparison result directly.
                        class_idx_q <= best_idx_d;
                        class_val_q <= fmt_val(best_d);
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_HOLD;
                    end else begin
                        k_q <= k_q + K_ONE;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign class_idx = class_idx_q;
    assign class_val = class_val_q;

endmodule

// File: tb/tb_sc_nn_decoder.sv
module tb_sc_nn_decoder;

    localparam int N2  = 10;
    localparam int L   = 8;
    localparam int WIN = 1 << L;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [N2-1:0] din;
    logic          din_valid;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    class_idx;
    logic [9:0]    class_val;

    int n_tot = 0;
    int n_bad = 0;

    sc_nn_decoder #(.N2(N2), .L(L)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .din       (din),
        .din_valid (din_valid),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .class_idx (class_idx),
        .class_val (class_val)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected output value for a winning count in the active encoding.
    function automatic logic [31:0] exp_val(input int best);
`ifdef SC_DEC_BIPOLAR_EN
        return (2 * best - WIN) & 32'h3FF;
`else
        return best;
`endif
    endfunction

    // Stimulus patterns: 0 one-hot class 3, 1 classes 2+7, 2 all zero,
    // 3 class 5 toggling per valid sample, 4 one-hot class 1, 5 random density.
    function automatic logic [N2-1:0] gen_din(input int pat, input int acc, input int prob[N2]);
        logic [N2-1:0] d;
        d = '0;
        case (pat)
            0: d[3] = 1'b1;
            1: begin d[2] = 1'b1; d[7] = 1'b1; end
            2: d = '0;
            3: d[5] = (acc % 2 == 0);
            4: d[1] = 1'b1;
            default: for (int i = 0; i < N2; i++) d[i] = ($urandom_range(0, 99) < prob[i]);
        endcase
        return d;
    endfunction

    // gap: 0 always valid, 1 alternating (invalid first), 2 random gaps.
    task automatic run_window(input int pat, input int gap, input int hold_n);
        int cnt[N2];
        int prob[N2];
        int acc, cyc, w, best, bidx;
        logic v;
        logic [N2-1:0] d;
        acc = 0;
        cyc = 0;
        for (int i = 0; i < N2; i++) begin
            cnt[i]  = 0;
            prob[i] = $urandom_range(0, 100);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        while (acc < WIN && cyc < 3000) begin
            case (gap)
                0: v = 1'b1;
                1: v = (cyc % 2 == 1);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            d = v ? gen_din(pat, acc, prob) : N2'($urandom);
            din       = d;
            din_valid = v;
            start     = ($urandom_range(0, 7) == 0);
            step();
            cyc++;
            if (v) begin
                for (int i = 0; i < N2; i++) cnt[i] += int'(d[i]);
                acc++;
            end
        end
        din_valid = 1'b0;
        start     = 1'b0;
        din       = '0;
        if (acc < WIN) begin
            chk("accum_timeout", acc, WIN);
            return;
        end
        if (gap == 1) chk("window_cycles", cyc, 2 * WIN);
        chk("scan_busy", busy, 1);
        chk("scan_not_valid", out_valid, 0);
        w = 0;
        while (!out_valid && w < 50) begin
            step();
            w++;
        end
        chk("latency", w, N2);
        best = -1;
        bidx = 0;
        for (int i = 0; i < N2; i++) begin
            if (cnt[i] > best) begin
                best = cnt[i];
                bidx = i;
            end
        end
        chk("hold_busy", busy, 0);
        out_ready = 1'b0;
        for (int j = 0; j < hold_n; j++) begin
            chk("hold_valid", out_valid, 1);
            chk("class_idx", class_idx, bidx);
            chk("class_val", class_val, exp_val(best));
            start = ($urandom_range(0, 1) == 1);
            step();
        end
        start = 1'b0;
        chk("class_idx_final", class_idx, bidx);
        chk("class_val_final", class_val, exp_val(best));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("idle_valid", out_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_idx_held", class_idx, bidx);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_idx", class_idx, 0);
        chk("rst_val", class_val, 0);
        reset = 1'b0;
        step();

        run_window(0, 0, 3);   // one-hot class 3
        run_window(1, 0, 2);   // tie 2 vs 7
        run_window(2, 0, 2);   // all zero
        run_window(3, 1, 2);   // alternating valid, class 5 half density

        // Abort mid-window with reset competing against start/valid/ready.
        start = 1'b1;
        step();
        start     = 1'b0;
        din       = N2'(1 << 1);
        din_valid = 1'b1;
        repeat (100) step();
        reset     = 1'b1;
        start     = 1'b1;
        out_ready = 1'b1;
        step();
        reset     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        din_valid = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_idx", class_idx, 0);
        chk("midrst_val", class_val, 0);
        step();
        chk("midrst_still_idle", busy, 0);
        run_window(4, 0, 2);   // fresh window after reset

        run_window(5, 0, 20);  // long hold with start pulses
        for (int r = 0; r < 6; r++) begin
            run_window(5, 2, $urandom_range(0, 5));
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/sc_nn_decoder.md
SC_NN_DECODER -- requirements
Module: sc_nn_decoder

Interface
REQ-001 SHALL have parameter N2, default 10: number of stochastic class streams.
REQ-002 SHALL have parameter L, default 8: window length is 2^L accepted samples.
REQ-003 SHALL derive localparam CW = L+1 (count width) and IW = $clog2(N2) (index width).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  begin a new decode window when idle.
REQ-007 SHALL have port din  input  N2  one stochastic bit per class, sampled per cycle.
REQ-008 SHALL have port din_valid  input  1  din is a valid sample this cycle.
REQ-009 SHALL have port busy  output  1  high in ACCUM and ARGMAX states.
REQ-010 SHALL have port out_valid  output  1  result available (HOLD state).
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port class_idx  output  IW  index of winning class.
REQ-013 SHALL have port class_val  output  CW+1  value of winning class (format per REQ-032).

Function
REQ-014 SHALL implement FSM states IDLE, ACCUM, ARGMAX, HOLD.
REQ-015 IDLE: start=1 SHALL clear all N2 counters and the sample counter and enter ACCUM next cycle.
REQ-016 ACCUM: each cycle with din_valid=1, counter[i] SHALL increment by din[i] for every i; sample counter increments by 1.
REQ-017 ACCUM: din_valid=0 cycles SHALL leave all counters unchanged; no limit on gaps.
REQ-018 Sample accepted when sample counter = 2^L-1 SHALL be counted, then FSM enters ARGMAX next cycle.
REQ-019 Counters SHALL be CW bits, max value 2^L; no saturation logic required, overflow impossible.
REQ-020 ARGMAX SHALL scan one class per cycle, k = 0..N2-1, exactly N2 cycles.
REQ-021 ARGMAX at k=0 SHALL load best=counter[0], best_idx=0; for k>0 SHALL replace only if counter[k] > best (strict).
REQ-022 Ties SHALL resolve to the lowest index.
REQ-023 After k=N2-1 FSM SHALL enter HOLD; out_valid=1 from that cycle.
REQ-024 Latency: last sample accepted in cycle t SHALL give out_valid=1 in cycle t+N2+1.
REQ-025 HOLD: class_idx and class_val SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 HOLD: out_valid=1 and out_ready=1 SHALL complete transfer; FSM enters IDLE next cycle, out_valid=0.
REQ-027 start SHALL be ignored in ACCUM, ARGMAX and HOLD; din/din_valid ignored outside ACCUM.
REQ-028 start in the IDLE cycle immediately after a HOLD handshake SHALL be accepted normally.
REQ-029 class_idx/class_val SHALL hold their last value outside HOLD; they are only meaningful when out_valid=1.

Reset
REQ-030 reset=1 at a clock edge SHALL force IDLE, busy=0, out_valid=0, class_idx=0, class_val=0, and all counters to 0, from any state including mid-window.
REQ-031 reset SHALL take priority over start, din_valid and out_ready in the same cycle.

Configuration
REQ-032 Macro SC_DEC_BIPOLAR_EN: when defined, class_val SHALL be the two's-complement bipolar value 2*best - 2^L (range -2^L..+2^L); when undefined, class_val SHALL be best zero-extended to CW+1 bits. Argmax, FSM and timing SHALL be identical in both builds.

Verification
REQ-033 N2=10, L=8: din[3]=1, others 0, 256 valid samples -> out_valid at t+11, class_idx=3, class_val=256 (both builds).
REQ-034 din[2]=din[7]=1 for 256 samples, others 0 -> class_idx=2 (tie to lowest index).
REQ-035 din=0 for 256 samples -> class_idx=0, class_val=0 unipolar / -256 with SC_DEC_BIPOLAR_EN.
REQ-036 din_valid alternating 1/0 with din[5] toggling, 128 ones among the valid samples -> window closes after 512 cycles, class_idx=5, class_val=128 unipolar / 0 bipolar.
REQ-037 reset pulsed at accepted sample 100 -> next cycle busy=0, out_valid=0; fresh start with din[1]=1 gives class_idx=1, class_val=256.
REQ-038 out_ready held 0 for 20 cycles in HOLD with start pulsed -> outputs stable, start ignored; out_ready=1 -> IDLE next cycle.
